// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan shift controller: sequencer states and MISR constants.
// The MISR constants are only consumed when SCAN_SHIFT_CTRL_MISR_EN is defined.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_FINISH
    } scan_state_e;

    // x^16 + x^12 + x^3 + x + 1, with the x^16 term implied by the shift-out
    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic din);
        logic [15:0] nxt;
        nxt = {sig[14:0], 1'b0};
        if (sig[15]) begin
            nxt = nxt ^ MISR_POLY;
        end
        return nxt ^ {15'd0, din};
    endfunction

endpackage

// File: rtl/scan_misr16.sv
// 16-bit single-input MISR that folds the scan-out stream during unload.
// Compiled only when SCAN_SHIFT_CTRL_MISR_EN is defined.
`ifdef SCAN_SHIFT_CTRL_MISR_EN
module scan_misr16
    import scan_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RN,
    input  logic        seed_i,
    input  logic        shift_i,
    input  logic        so_i,
    output logic [15:0] sig_o
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (seed_i) begin
            sig_d = MISR_SEED;
        end else if (shift_i) begin
            sig_d = misr_step(sig_q, so_i);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule
`endif

// File: rtl/scan_shift_ctrl.sv
// Scan chain sequencer: serial load, functional capture, serial unload of one pattern.
// Optional signature output SIG (MISR over SO) when SCAN_SHIFT_CTRL_MISR_EN is defined.
module scan_shift_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CAP_CYC   = 1
)
(
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP
`ifdef SCAN_SHIFT_CTRL_MISR_EN
    ,
    output logic [15:0]          SIG
`endif
);

    // Wide enough for the longer of the shift and capture phases so neither can wrap
    localparam int unsigned LEN_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned CAP_W = $clog2(CAP_CYC + 1);
    localparam int unsigned CNT_W = (LEN_W > CAP_W) ? LEN_W : CAP_W;

    localparam logic [CNT_W-1:0] LAST_LEN = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(CAP_CYC - 1);

    scan_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CHAIN_LEN-1:0]   sh_q;
    logic [CHAIN_LEN-1:0]   resp_q;
    logic                   se_q;
    logic                   si_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   arm_q;
    logic                   accept;

    // arm_q keeps START blind for the first edge after reset release
    assign accept = (state_q == ST_IDLE) && START && arm_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            resp_q  <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            arm_q  <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        sh_q    <= {PAT_IN[CHAIN_LEN-2:0], 1'b0};
                        se_q    <= 1'b1;
                        si_q    <= PAT_IN[CHAIN_LEN-1];
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == LAST_LEN) begin
                        state_q <= ST_CAPTURE;
                        cnt_q   <= '0;
                        se_q    <= 1'b0;
                        si_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        si_q  <= sh_q[CHAIN_LEN-1];
                        sh_q  <= {sh_q[CHAIN_LEN-2:0], 1'b0};
                    end
                end
                ST_CAPTURE: begin
                    if (cnt_q == LAST_CAP) begin
                        state_q <= ST_UNLOAD;
                        cnt_q   <= '0;
                        se_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_UNLOAD: begin
                    // First SO sample ends up in the MSB after CHAIN_LEN shifts
                    resp_q <= {resp_q[CHAIN_LEN-2:0], SO};
                    if (cnt_q == LAST_LEN) begin
                        state_q <= ST_FINISH;
                        cnt_q   <= '0;
                        se_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    se_q    <= 1'b0;
                    si_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SE   = se_q;
    assign SI   = si_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign RESP = resp_q;

`ifdef SCAN_SHIFT_CTRL_MISR_EN
    scan_misr16 u_misr (
        .CLK     (CLK),
        .RN      (RN),
        .seed_i  (accept),
        .shift_i (state_q == ST_UNLOAD),
        .so_i    (SO),
        .sig_o   (SIG)
    );
`endif

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Randomized self-checking bench: two controllers (capture 1 and 2 cycles) each driving a
// 16-flop scan chain whose functional D is NOT Q, compared against a cycle-index model.
module tb_scan_shift_ctrl;

    localparam int L  = 16;
    localparam int CA = 1;
    localparam int CB = 2;

    logic         clk   = 1'b0;
    logic         rn    = 1'b1;
    logic         start = 1'b0;
    logic [L-1:0] pat   = '0;

    logic         so_a, se_a, si_a, busy_a, done_a;
    logic         so_b, se_b, si_b, busy_b, done_b;
    logic [L-1:0] resp_a, resp_b, chain_a, chain_b;
`ifdef SCAN_SHIFT_CTRL_MISR_EN
    logic [15:0]  sig_a, sig_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_shift_ctrl #(.CHAIN_LEN(L), .CAP_CYC(CA)) dut_a (
        .CLK(clk), .RN(rn), .START(start), .PAT_IN(pat), .SO(so_a),
        .SE(se_a), .SI(si_a), .BUSY(busy_a), .DONE(done_a), .RESP(resp_a)
`ifdef SCAN_SHIFT_CTRL_MISR_EN
        , .SIG(sig_a)
`endif
    );

    scan_shift_ctrl #(.CHAIN_LEN(L), .CAP_CYC(CB)) dut_b (
        .CLK(clk), .RN(rn), .START(start), .PAT_IN(pat), .SO(so_b),
        .SE(se_b), .SI(si_b), .BUSY(busy_b), .DONE(done_b), .RESP(resp_b)
`ifdef SCAN_SHIFT_CTRL_MISR_EN
        , .SIG(sig_b)
`endif
    );

    // Scan chains: shift toward the tail with SE, otherwise invert every flop
    always @(posedge clk or negedge rn) begin
        if (!rn)       chain_a <= '0;
        else if (se_a) chain_a <= {chain_a[L-2:0], si_a};
        else           chain_a <= ~chain_a;
    end
    always @(posedge clk or negedge rn) begin
        if (!rn)       chain_b <= '0;
        else if (se_b) chain_b <= {chain_b[L-2:0], si_b};
        else           chain_b <= ~chain_b;
    end
    assign so_a = chain_a[L-1];
    assign so_b = chain_b[L-1];

    // Reference model: run index k counts edges since the accepting edge
    logic         act_m [2];
    int           k_m   [2];
    logic [L-1:0] pat_m [2];
    logic [L-1:0] old_m [2];
    logic         armed_m;

    function automatic int capc(input int i);
        return (i == 0) ? CA : CB;
    endfunction

    function automatic logic [L-1:0] captured(input logic [L-1:0] p, input int c);
        return (c % 2 == 1) ? ~p : p;
    endfunction

    function automatic logic [15:0] misr_fold(input logic [L-1:0] v);
        logic [16:0] s;
        s = 17'h0FFFF;
        for (int b = L - 1; b >= 0; b--) begin
            s = s << 1;
            if (s[16]) s = s ^ 17'h1100B;
            s[0] = s[0] ^ v[b];
        end
        return s[15:0];
    endfunction

    always @(posedge clk or negedge rn) begin
        if (!rn) begin
            for (int i = 0; i < 2; i++) begin
                act_m[i] <= 1'b0;
                k_m[i]   <= 0;
                old_m[i] <= '0;
            end
            armed_m <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act_m[i]) begin
                    if (k_m[i] == 2 * L + capc(i)) begin
                        act_m[i] <= 1'b0;
                        old_m[i] <= captured(pat_m[i], capc(i));
                    end else begin
                        k_m[i] <= k_m[i] + 1;
                    end
                end else if (start && armed_m) begin
                    act_m[i] <= 1'b1;
                    k_m[i]   <= 0;
                    pat_m[i] <= pat;
                end
            end
            armed_m <= 1'b1;
        end
    end

    // Literal pins for selected runs, set by the stimulus
    logic         pin_en = 1'b0;
    logic [L-1:0] pin_si = '0;
    int           pin_lat  [2];
    logic [L-1:0] pin_resp [2];
    logic [L-1:0] si_rec   [2];

    task automatic chk(input string nm, input int inst, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, got, exp);
        end
    endtask

    logic         e_se, e_si, e_busy, e_done, g_se, g_si, g_busy, g_done;
    logic [L-1:0] e_resp, g_resp, capv;
    int           kk, c, j;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            g_se   = (i == 0) ? se_a   : se_b;
            g_si   = (i == 0) ? si_a   : si_b;
            g_busy = (i == 0) ? busy_a : busy_b;
            g_done = (i == 0) ? done_a : done_b;
            g_resp = (i == 0) ? resp_a : resp_b;
            c      = capc(i);
            kk     = k_m[i];
            capv   = captured(pat_m[i], c);
            e_se = 1'b0; e_si = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_resp = old_m[i];
            if (act_m[i]) begin
                if (kk < L) begin
                    e_se = 1'b1; e_si = pat_m[i][L-1-kk]; e_busy = 1'b1;
                    si_rec[i][L-1-kk] = g_si;
                end else if (kk < L + c) begin
                    e_busy = 1'b1;
                end else if (kk < 2 * L + c) begin
                    e_se = 1'b1; e_busy = 1'b1;
                end else begin
                    e_done = 1'b1;
                end
                j = kk - (L + c);
                if (j < 0) j = 0;
                if (j > L) j = L;
                if (j == L)     e_resp = capv;
                else if (j > 0) e_resp = (old_m[i] << j) | (capv >> (L - j));
            end
            chk("se",   i, 64'(g_se),   64'(e_se));
            chk("si",   i, 64'(g_si),   64'(e_si));
            chk("busy", i, 64'(g_busy), 64'(e_busy));
            chk("done", i, 64'(g_done), 64'(e_done));
            chk("resp", i, 64'(g_resp), 64'(e_resp));
            if (act_m[i] && kk == 2 * L + c) begin
                if (pin_en) begin
                    chk("pin_done_cycle", i, 64'(g_done ? kk + 1 : 0), 64'(pin_lat[i]));
                    chk("pin_resp",       i, 64'(g_resp), 64'(pin_resp[i]));
                    if (i == 0) chk("pin_si_seq", i, 64'(si_rec[0]), 64'(pin_si));
                end
`ifdef SCAN_SHIFT_CTRL_MISR_EN
                chk("sig", i, 64'((i == 0) ? sig_a : sig_b), 64'(misr_fold(capv)));
`endif
            end
            if (!rn) begin
                chk("rst_se",   i, 64'(g_se),   64'd0);
                chk("rst_busy", i, 64'(g_busy), 64'd0);
                chk("rst_resp", i, 64'(g_resp), 64'd0);
            end
        end
    end

    task automatic pulse_start(input logic [L-1:0] p);
        @(negedge clk);
        pat   = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        pin_lat[0] = 0; pin_lat[1] = 0;
        pin_resp[0] = '0; pin_resp[1] = '0;
        // Reset with START held through the first cycle after release
        #1 rn = 1'b0;
        start = 1'b1;
        pat   = 16'h1234;
        repeat (3) @(negedge clk);
        rn = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Hand-computed runs
        pin_en = 1'b1;
        pin_si = 16'hA5C3;
        pin_lat[0] = 34;       pin_lat[1] = 35;
        pin_resp[0] = 16'h5A3C; pin_resp[1] = 16'hA5C3;
        pulse_start(16'hA5C3);
        repeat (40) @(negedge clk);
        pin_si = 16'h0000;
        pin_resp[0] = 16'hFFFF; pin_resp[1] = 16'h0000;
        pulse_start(16'h0000);
        repeat (40) @(negedge clk);
        pin_en = 1'b0;

        // START retried at cycles 5 and 33 (ignored) and 35 (accepted by the CAP_CYC=1 unit)
        pulse_start(16'(($urandom)));
        for (int cyc = 2; cyc <= 36; cyc++) begin
            @(negedge clk);
            start = (cyc == 5 || cyc == 33 || cyc == 35);
            if (cyc == 35) pat = 16'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Random START traffic
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            pat   = 16'($urandom);
            start = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the eighth UNLOAD cycle, then a full sequence
        pulse_start(16'($urandom));
        repeat (24) @(posedge clk);
        #2 rn = 1'b0;
        repeat (2) @(negedge clk);
        rn = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start(16'($urandom));
        repeat (40) @(negedge clk);

        // All-ones pattern: SO stream is sixteen zeros for the CAP_CYC=1 unit
        pulse_start(16'hFFFF);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_shift_ctrl.md
SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

Interface
REQ-001 SHALL provide parameter CHAIN_LEN, default 16, length of the driven scan chain in flops (legal 2..64).
REQ-002 SHALL provide parameter CAP_CYC, default 1, number of functional capture cycles with SE low (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous active-low reset: CLK  input  1  rising-edge clock, shared with the scan flops.
REQ-004 RN  input  1  asynchronous active-low reset.
REQ-005 START  input  1  single-cycle request to run one load/capture/unload sequence.
REQ-006 PAT_IN  input  CHAIN_LEN  stimulus pattern; bit k is destined for chain flop k (flop 0 nearest SI).
REQ-007 SO  input  1  scan-out from the chain tail (flop CHAIN_LEN-1 Q).
REQ-008 SE  output  1  scan enable to every chain flop.
REQ-009 SI  output  1  serial data to chain head.
REQ-010 BUSY  output  1  high from the cycle after an accepted START until DONE.
REQ-011 DONE  output  1  one-cycle pulse, response valid.
REQ-012 RESP  output  CHAIN_LEN  unloaded response; bit k = value captured in chain flop k.

Function
REQ-013 SHALL implement states IDLE, LOAD, CAPTURE, UNLOAD, FINISH, encoded in the package enum.
REQ-014 IDLE: SE=0, SI=0, BUSY=0; START=1 latches PAT_IN into the shift register and moves to LOAD.
REQ-015 LOAD: SE=1 for exactly CHAIN_LEN cycles; SI presents PAT_IN[CHAIN_LEN-1] first, PAT_IN[0] last, one bit per cycle.
REQ-016 CAPTURE: SE=0, SI=0 for exactly CAP_CYC cycles.
REQ-017 UNLOAD: SE=1, SI=0 for exactly CHAIN_LEN cycles; SO sampled every rising edge, first sample to RESP[CHAIN_LEN-1], last to RESP[0].
REQ-018 FINISH: one cycle, SE=0, DONE=1, BUSY=0, then IDLE.
REQ-019 Latency: accepted START at edge n SHALL yield DONE high in cycle n+2*CHAIN_LEN+CAP_CYC+1.
REQ-020 START while not in IDLE SHALL be ignored; no queuing.
REQ-021 START in the FINISH cycle SHALL be ignored; START in the following IDLE cycle SHALL be accepted.
REQ-022 RESP SHALL hold its value from FINISH until the next UNLOAD begins updating it.
REQ-023 Cycle counter SHALL be ceil(log2(CHAIN_LEN+1)) bits, never wrap within a phase, reload to zero at each phase change.

Reset
REQ-024 RN low SHALL asynchronously force IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESP=0, counter=0, aborting any sequence mid-operation.
REQ-025 START asserted while RN low or in the first cycle after RN deasserts SHALL be ignored.

Configuration
REQ-026 Macro SCAN_SHIFT_CTRL_MISR_EN defined: add output SIG (16 bits), a 16-bit MISR (poly x^16+x^12+x^3+x+1, seed 0xFFFF at START) folding SO each UNLOAD cycle; SIG stable from FINISH.
REQ-027 Macro undefined: no SIG port, no MISR logic; all other behaviour identical.

Structure
REQ-028 Shared package scan_ctrl_pkg SHALL hold the state enum, MISR polynomial and seed constants.
REQ-029 MISR SHALL be sub-module scan_misr16, instantiated only under SCAN_SHIFT_CTRL_MISR_EN.

Verification
(Bench model: 16-flop scan-FF chain with async set/reset, functional D of flop k = NOT Q of flop k.)
REQ-030 PAT_IN=0xA5C3, START -> SE high 16 cycles, SI sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; DONE at cycle 34; RESP=0x5A3C.
REQ-031 PAT_IN=0x0000, CAP_CYC=2 -> RESP=0x0000 (double inversion); DONE at cycle 35.
REQ-032 START pulsed again at cycles 5 and 33 of a run -> ignored; single DONE; START at cycle 35 accepted.
REQ-033 RN low during UNLOAD cycle 8 -> SE, BUSY, RESP immediately 0; state IDLE; next START runs a full sequence.
REQ-034 With SCAN_SHIFT_CTRL_MISR_EN, PAT_IN=0xFFFF -> SIG equals golden-model MISR of sixteen SO zeros from seed 0xFFFF; without macro the build has no SIG port.
